// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX parity path: parity mode encodings,
// smallest legal runtime data length and the parity FSM state encoding.
package uart_tx_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    localparam int unsigned MIN_LEN = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : uart_tx_pkg

// File: rtl/tx_parity_core.sv
// Combinational parity core: clamps the runtime length into
// [MIN_LEN, DATA_WIDTH], masks the word above that length and applies the
// selected parity mode.
module tx_parity_core
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MIN_LEN    = 5,
    parameter int unsigned LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [LEN_W-1:0]      len,
    input  logic [1:0]            mode,
    output logic                  par_c
);

    logic [LEN_W-1:0]      eff_len;
    logic [DATA_WIDTH-1:0] mask;
    logic                  even;

    // Clamp the requested length into the supported range.
    always_comb begin
        eff_len = len;
        if (len < LEN_W'(MIN_LEN)) begin
            eff_len = LEN_W'(MIN_LEN);
        end else if (len > LEN_W'(DATA_WIDTH)) begin
            eff_len = LEN_W'(DATA_WIDTH);
        end
    end

    // Keep only bits below the effective length.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            mask[i] = (LEN_W'(i) < eff_len);
        end
    end

    assign even = ^(word & mask);

    // Mode select; mark and space ignore the data entirely.
    always_comb begin
        par_c = 1'b0;
        case (mode)
            PAR_EVEN: par_c = even;
            PAR_ODD:  par_c = ~even;
            PAR_MARK: par_c = 1'b1;
            default:  par_c = 1'b0;
        endcase
    end

endmodule : tx_parity_core

// File: rtl/uart_tx_parity_gen.sv
// UART TX parity generator: captures a word on data_valid, registers its
// parity and holds it with a valid/ack handshake; words arriving while a
// result is pending are dropped and flagged on the sticky ovf output.
// Optional feature macro: UART_PARITY_ERR_INJECT_EN adds inject_err, which
// inverts the captured parity bit for receiver error-path testing.
module uart_tx_parity_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MIN_LEN    = uart_tx_pkg::MIN_LEN,
    localparam int unsigned LEN_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic [LEN_W-1:0]      data_len,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic [1:0]            par_mode,
    input  logic                  par_ack,
    input  logic                  ovf_clr,
`ifdef UART_PARITY_ERR_INJECT_EN
    input  logic                  inject_err,
`endif
    output logic                  par_bit,
    output logic                  par_valid,
    output logic                  busy,
    output logic                  ovf
);

    state_t state_q;
    state_t state_d;
    logic   par_bit_d;
    logic   ovf_set;
    logic   core_par_c;
    logic   cap_par_c;

    tx_parity_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .MIN_LEN    (MIN_LEN),
        .LEN_W      (LEN_W)
    ) u_core (
        .word  (p_data),
        .len   (data_len),
        .mode  (par_mode),
        .par_c (core_par_c)
    );

`ifdef UART_PARITY_ERR_INJECT_EN
    assign cap_par_c = core_par_c ^ inject_err;
`else
    assign cap_par_c = core_par_c;
`endif

    // State, parity bit and sticky overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            par_bit <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            par_bit <= par_bit_d;
            ovf     <= ovf_set | (ovf & ~ovf_clr);
        end
    end

    // Next state, next parity bit and overflow detection.
    always_comb begin
        state_d   = state_q;
        par_bit_d = par_bit;
        ovf_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_valid && par_en) begin
                    state_d   = HOLD;
                    par_bit_d = cap_par_c;
                end
            end
            HOLD: begin
                if (par_ack) begin
                    if (data_valid && par_en) begin
                        par_bit_d = cap_par_c;
                    end else begin
                        state_d   = IDLE;
                        par_bit_d = 1'b0;
                    end
                end else if (data_valid) begin
                    ovf_set = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                par_bit_d = 1'b0;
            end
        endcase
    end

    // Status outputs decode the state register directly.
    assign par_valid = (state_q == HOLD);
    assign busy      = (state_q == HOLD);

endmodule : uart_tx_parity_gen

// File: tb/tb_uart_tx_parity_gen.sv
// Self-checking bench for uart_tx_parity_gen. Expected parity bits are
// queued when a capture is driven and compared when par_valid is observed.
module tb_uart_tx_parity_gen;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned LEN_W      = $clog2(DATA_WIDTH + 1);
    localparam logic [1:0]  M_EVEN     = 2'b00;
    localparam logic [1:0]  M_ODD      = 2'b01;
    localparam logic [1:0]  M_MARK     = 2'b10;
    localparam logic [1:0]  M_SPACE    = 2'b11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DATA_WIDTH-1:0] p_data;
    logic [LEN_W-1:0]      data_len;
    logic                  data_valid;
    logic                  par_en;
    logic [1:0]            par_mode;
    logic                  par_ack;
    logic                  ovf_clr;
    logic                  inject_err;
    logic                  par_bit;
    logic                  par_valid;
    logic                  busy;
    logic                  ovf;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .MIN_LEN    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_len   (data_len),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_mode   (par_mode),
        .par_ack    (par_ack),
        .ovf_clr    (ovf_clr),
`ifdef UART_PARITY_ERR_INJECT_EN
        .inject_err (inject_err),
`endif
        .par_bit    (par_bit),
        .par_valid  (par_valid),
        .busy       (busy),
        .ovf        (ovf)
    );

    // Reference parity: clamp length to [5, 8], XOR the low bits, apply mode.
    function automatic logic model_par(input logic [DATA_WIDTH-1:0] d,
                                       input logic [LEN_W-1:0] len,
                                       input logic [1:0] mode);
        int   l;
        logic x;
        l = int'(len);
        if (l < 5) l = 5;
        if (l > 8) l = 8;
        x = 1'b0;
        for (int i = 0; i < l; i++) x = x ^ d[i];
        case (mode)
            M_EVEN:  return x;
            M_ODD:   return ~x;
            M_MARK:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Oldest expected value; X when nothing was queued so the compare fails.
    function automatic logic pop_exp();
        if (exp_q.size() == 0) return 1'bx;
        return exp_q.pop_front();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one data_valid cycle; optionally queue the expected parity.
    task automatic capture(input logic [DATA_WIDTH-1:0] d, input logic [LEN_W-1:0] len,
                           input logic [1:0] mode, input logic en, input logic ack,
                           input logic inj, input logic push, input logic exp);
        p_data     = d;
        data_len   = len;
        par_mode   = mode;
        par_en     = en;
        par_ack    = ack;
        inject_err = inj;
        data_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        tick();
        data_valid = 1'b0;
        par_ack    = 1'b0;
        inject_err = 1'b0;
    endtask

    task automatic ack_only();
        par_ack = 1'b1;
        tick();
        par_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic e;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({par_bit, par_valid, busy, ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got %b expected 0000", {par_bit, par_valid, busy, ovf});
        end
        rst = 1'b1;
        tick();
        capture(8'h00, 4'd8, M_MARK, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        e = pop_exp();
        checks++;
        if (par_valid !== 1'b1 || par_bit !== e) begin
            errors++;
            $display("FAIL reset_pre_capture: valid=%b bit=%b expected valid=1 bit=%b", par_valid, par_bit, e);
        end
        capture(8'h00, 4'd8, M_SPACE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_ovf: got %b expected 1", ovf);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({par_bit, par_valid, busy, ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_mid_hold: got %b expected 0000", {par_bit, par_valid, busy, ovf});
        end
        exp_q.delete();
        rst = 1'b1;
        tick();
    endtask

    task automatic run_table(input string name, input logic [DATA_WIDTH-1:0] d,
                             input logic [LEN_W-1:0] len, input logic [1:0] mode, input logic exp);
        logic e;
        capture(d, len, mode, 1'b1, 1'b0, 1'b0, 1'b1, exp);
        e = pop_exp();
        checks++;
        if (par_valid !== 1'b1 || par_bit !== e) begin
            errors++;
            $display("FAIL %s: valid=%b bit=%b expected valid=1 bit=%b", name, par_valid, par_bit, e);
        end
        ack_only();
        checks++;
        if (par_valid !== 1'b0 || busy !== 1'b0 || par_bit !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack: valid=%b busy=%b bit=%b expected 0 0 0", name, par_valid, busy, par_bit);
        end
    endtask

    task automatic test_even_odd();
        run_table("even_a9", 8'b10101001, 4'd8, M_EVEN, 1'b0);
        run_table("odd_a9",  8'b10101001, 4'd8, M_ODD,  1'b1);
        run_table("even_ad", 8'b10101101, 4'd8, M_EVEN, 1'b1);
    endtask

    task automatic test_masking();
        run_table("mask_ff_len7",   8'hFF,       4'd7,  M_EVEN, 1'b1);
        run_table("mask_e0_len5",   8'b11100000, 4'd5,  M_EVEN, 1'b0);
        run_table("clamp_len5",     8'b00010110, 4'd5,  M_EVEN, 1'b1);
        run_table("clamp_len3",     8'b00010110, 4'd3,  M_EVEN, 1'b1);
        run_table("clamp_len15",    8'hFF,       4'd15, M_EVEN, 1'b0);
    endtask

    task automatic test_mark_space();
        run_table("mark_00",  8'h00, 4'd8, M_MARK,  1'b1);
        run_table("mark_ff",  8'hFF, 4'd6, M_MARK,  1'b1);
        run_table("space_ff", 8'hFF, 4'd8, M_SPACE, 1'b0);
        run_table("space_01", 8'h01, 4'd5, M_SPACE, 1'b0);
    endtask

    task automatic test_disabled();
        capture(8'h01, 4'd8, M_MARK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (par_valid !== 1'b0 || busy !== 1'b0 || par_bit !== 1'b0) begin
            errors++;
            $display("FAIL disabled_capture: valid=%b busy=%b bit=%b expected 0 0 0", par_valid, busy, par_bit);
        end
        ack_only();
        checks++;
        if (par_valid !== 1'b0 || par_bit !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: valid=%b bit=%b expected 0 0", par_valid, par_bit);
        end
    endtask

    task automatic test_handshake();
        logic e;
        capture(8'b10101101, 4'd8, M_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        e = pop_exp();
        checks++;
        if (par_valid !== 1'b1 || par_bit !== e) begin
            errors++;
            $display("FAIL hs_capture: valid=%b bit=%b expected valid=1 bit=%b", par_valid, par_bit, e);
        end
        p_data   = 8'h00;
        par_mode = M_SPACE;
        data_len = 4'd5;
        tick();
        checks++;
        if (par_bit !== 1'b1 || par_valid !== 1'b1) begin
            errors++;
            $display("FAIL hs_sample_hold: bit=%b valid=%b expected 1 1", par_bit, par_valid);
        end
        capture(8'b10101001, 4'd8, M_EVEN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ovf !== 1'b1 || par_bit !== 1'b1 || par_valid !== 1'b1) begin
            errors++;
            $display("FAIL hs_drop: ovf=%b bit=%b valid=%b expected 1 1 1", ovf, par_bit, par_valid);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL hs_ovf_clr: got %b expected 0", ovf);
        end
        ovf_clr = 1'b1;
        capture(8'h00, 4'd8, M_MARK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1 || par_bit !== 1'b1) begin
            errors++;
            $display("FAIL hs_set_wins: ovf=%b bit=%b expected 1 1", ovf, par_bit);
        end
        capture(8'b10101001, 4'd8, M_EVEN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        e = pop_exp();
        checks++;
        if (par_valid !== 1'b1 || par_bit !== e) begin
            errors++;
            $display("FAIL hs_ack_capture: valid=%b bit=%b expected valid=1 bit=%b", par_valid, par_bit, e);
        end
        capture(8'hFF, 4'd8, M_MARK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (par_valid !== 1'b0 || busy !== 1'b0 || par_bit !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL hs_ack_disabled: valid=%b busy=%b bit=%b ovf=%b expected 0 0 0 1",
                     par_valid, busy, par_bit, ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_WIDTH-1:0] d;
        logic [LEN_W-1:0]      len;
        logic [1:0]            mode;
        logic                  e;
        int                    bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            d    = DATA_WIDTH'($urandom);
            len  = LEN_W'($urandom_range(0, 15));
            mode = 2'($urandom_range(0, 3));
            capture(d, len, mode, 1'b1, (i != 0), 1'b0, 1'b1, model_par(d, len, mode));
            e = pop_exp();
            checks++;
            if (par_valid !== 1'b1 || par_bit !== e || ovf !== 1'b0) begin
                errors++;
                bad++;
                $display("FAIL b2b_%0d: valid=%b bit=%b ovf=%b expected valid=1 bit=%b ovf=0 (d=%h len=%0d mode=%0d)",
                         i, par_valid, par_bit, ovf, e, d, len, mode);
            end
        end
        ack_only();
        checks++;
        if (par_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b queued=%0d expected 0 0", par_valid, exp_q.size());
        end
    endtask

`ifdef UART_PARITY_ERR_INJECT_EN
    task automatic test_inject();
        logic e;
        capture(8'b10101001, 4'd8, M_EVEN, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        e = pop_exp();
        checks++;
        if (par_valid !== 1'b1 || par_bit !== e) begin
            errors++;
            $display("FAIL inject_even: valid=%b bit=%b expected valid=1 bit=%b", par_valid, par_bit, e);
        end
        ack_only();
    endtask
`endif

    initial begin
        rst        = 1'b1;
        p_data     = '0;
        data_len   = LEN_W'(8);
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_mode   = M_EVEN;
        par_ack    = 1'b0;
        ovf_clr    = 1'b0;
        inject_err = 1'b0;
        #2;
        test_reset();
        test_even_odd();
        test_masking();
        test_mark_space();
        test_disabled();
        test_handshake();
        test_back_to_back();
`ifdef UART_PARITY_ERR_INJECT_EN
        test_inject();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound the run in case the sequence above never completes.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule : tb_uart_tx_parity_gen

// File: doc/uart_tx_parity_gen.md
# uart_tx_parity_gen

Parametrised parity generator for the UART transmitter, sitting between the TX input register and the frame serializer. It captures a data word on `data_valid` and computes the parity over a runtime-selectable data length, using one of four parity modes. It holds the result with a valid/ack handshake until the serializer consumes it, and flags words that arrive while a result is still pending.

## Interface
- `DATA_WIDTH`, 8, maximum data word width, legal 5..16
- `MIN_LEN`, 5, smallest supported runtime data length
- `LEN_W`, `$clog2(DATA_WIDTH+1)`, width of `data_len` (derived, not overridden)

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `p_data` in `DATA_WIDTH`: parallel data word; bit 0 is sent first.
- `data_len` in `LEN_W`: number of valid data bits, counted from bit 0.
- `data_valid` in 1: capture strobe for `p_data`.
- `par_en` in 1: parity enabled for this frame.
- `par_mode` in 2: 00 even, 01 odd, 10 mark, 11 space.
- `par_ack` in 1: serializer has consumed `par_bit`.
- `ovf_clr` in 1: clears `ovf`.
- `inject_err` in 1: present only with `UART_PARITY_ERR_INJECT_EN`.
- `par_bit` out 1: registered parity bit.
- `par_valid` out 1: `par_bit` holds a valid, unconsumed result.
- `busy` out 1: high in HOLD.
- `ovf` out 1: sticky; a word was dropped.

## Operation
- **Length clamp:** effective length L = `data_len` clamped to [`MIN_LEN`, `DATA_WIDTH`]. Bits at index ≥ L are masked to 0 before parity is computed.
- **Parity per mode:**
  - even = XOR of the masked word
  - odd = inverse of the even result
  - mark = 1
  - space = 0
- **State machine:** two states, IDLE and HOLD.
  - **IDLE:**
    - `data_valid` && `par_en`: capture the word, register `par_bit`, go to HOLD.
    - `data_valid` && !`par_en`: ignored; state unchanged; `par_bit` stays 0.
    - `par_ack`: ignored.
  - **HOLD:**
    - `par_ack` && !`data_valid`: go to IDLE.
    - `par_ack` && `data_valid` && `par_en`: back-to-back capture; stay in HOLD; `par_bit` updates; `par_valid` stays 1.
    - `par_ack` && `data_valid` && !`par_en`: go to IDLE.
    - `data_valid` && !`par_ack`: word dropped; `ovf` set; `par_bit` unchanged.
- **Sampling:** `par_mode`, `data_len` and `p_data` are sampled only at capture. Changing them in HOLD does not alter the held `par_bit`.
- **Outputs per state:**
  - `par_valid` = `busy` = (state == HOLD).
  - `par_bit` is cleared to 0 on every transition to IDLE.
- **`ovf` rules:**
  - Sticky; cleared by `ovf_clr`.
  - If set and clear occur in the same cycle, set wins.
- **Reset:** asynchronous assertion, at any point including mid-HOLD, forces:
  - state IDLE
  - `par_bit` 0, `par_valid` 0, `busy` 0, `ovf` 0
  - any pending result is discarded

## Timing
- Latency: `data_valid` at edge N produces `par_bit`/`par_valid` valid after edge N; the serializer sees them in cycle N+1.
- Throughput: one word per cycle when `par_ack` accompanies each new `data_valid`.
- `par_ack` at edge M: `par_valid` is low after edge M, unless a back-to-back capture happens at the same edge.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- `UART_PARITY_ERR_INJECT_EN` defined:
  - Adds the `inject_err` port.
  - When `inject_err` is high at capture, the captured `par_bit` is inverted in all four modes, for receiver error-path testing.
- Not defined:
  - No `inject_err` port.
  - Parity is always correct.

## Structure
- Package `uart_tx_pkg` holds:
  - `par_mode` encodings as named constants (`PAR_EVEN`, `PAR_ODD`, `PAR_MARK`, `PAR_SPACE`)
  - `MIN_LEN`
  - the IDLE/HOLD state encoding
- Sub-module `tx_parity_core`: combinational length clamp, mask and mode select. Returns the parity for (word, L, mode). The top level holds the FSM, registers and `ovf`.

## Test plan
- **Reset:** assert `rst`=0 mid-HOLD → `par_valid`, `par_bit`, `busy`, `ovf` go to 0 immediately, without waiting for a clock edge.
- **Even/odd, full length:** `data_len`=8.
  - `p_data`=8'b10101001, even → `par_bit`=0.
  - Same word, odd → 1.
  - `p_data`=8'b10101101, even → 1.
  - `par_valid` high one cycle after `data_valid` in every case.
- **Masking:**
  - `p_data`=8'hFF, `data_len`=7, even → 1.
  - `p_data`=8'b11100000, `data_len`=5, even → 0.
  - `data_len`=3 is clamped to 5: same result as 5.
- **Mark/space/disabled:**
  - mark → `par_bit`=1; space → 0; both regardless of data.
  - `par_en`=0 with `data_valid` → stays IDLE, `par_valid`=0.
- **Handshake:**
  - Second `data_valid` in HOLD without `par_ack` → `ovf`=1, `par_bit` unchanged.
  - `data_valid`+`par_ack` together → new `par_bit`, `par_valid` stays 1.
  - `ovf_clr` and an overflow in the same cycle → `ovf` stays 1.
- **Injection** (macro defined): `inject_err`=1, even, 8'b10101001 → `par_bit`=1.
